// File: rtl/main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl
//   Main-memory port controller that sits behind the memory execution element.
//   It serialises the read channel (loads) and the write channel (stores) onto
//   a single-port synchronous SRAM with a fixed read latency. Each request is
//   answered with a one-cycle ready pulse. Requesters hold valid, address and
//   data stable until they see that pulse.
//
//   Optional feature (compile-time macro MAIN_MEM_CTRL_RANGE_CHECK_EN):
//     When the macro is defined, an address is out of range if it has any bit
//     above the SRAM word index set, or if it is not word aligned.
//     - An out-of-range write does not assert sram_we.
//     - An out-of-range read returns zero.
//     - The sticky output range_err records that such an access happened.
//     When the macro is not defined, addresses wrap modulo the SRAM depth.
//
// Parameters
//   ADDR_W        SRAM word-address width (2**ADDR_W words of 32 bits)
//   READ_LATENCY  cycles from sram_addr presented to sram_rdata valid (>=1)
//
// Ports
//   clk, reset   rising-edge clock; synchronous active-high reset
//   rd_addr      read byte address        rd_valid  read request
//   rd_data      read data (held)         rd_ready  read done pulse
//   wr_addr      write byte address       wr_data   write data
//   wr_valid     write request            wr_ready  write done pulse
//   sram_addr    SRAM word address        sram_wdata SRAM write data
//   sram_we      SRAM write enable        sram_rdata SRAM read data
//   busy         controller not idle (registered)
//   range_err    sticky out-of-range flag (only with the range-check macro)
// -----------------------------------------------------------------------------
module main_mem_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       rd_addr,
  input  logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_ready,
  input  logic [31:0]       wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  input  logic [31:0]       sram_rdata,
  output logic              busy
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
  ,
  output logic              range_err
`endif
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(READ_LATENCY);
  // The write needs one cycle with sram_we high and one quiet cycle before
  // ready, so that the ready pulse lands two cycles after accept.
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nxt;
  logic [31:0]         r_sram_wdata, w_sram_wdata_nxt;
  logic                r_sram_we, w_sram_we_nxt;
  logic [31:0]         r_rd_data, w_rd_data_nxt;
  logic                r_rd_ready, w_rd_ready_nxt;
  logic                r_wr_ready, w_wr_ready_nxt;
  logic                r_busy;
  logic                r_is_wr, w_is_wr_nxt;   // the access in flight is a write
  logic                r_oor, w_oor_nxt;       // the access in flight is out of range
  logic [ADDR_W-1:0]   w_wr_idx, w_rd_idx;
  logic                w_wr_oor, w_rd_oor;

  assign w_wr_idx = wr_addr[ADDR_W+1:2];
  assign w_rd_idx = rd_addr[ADDR_W+1:2];

`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
  logic r_range_err, w_range_err_nxt;

  // True when any bit above the word index is set, or when the byte offset is nonzero.
  function automatic logic out_of_range(input logic [31:0] addr);
    return ((addr >> (ADDR_W + 2)) != 32'd0) || (addr[1:0] != 2'b00);
  endfunction

  assign w_wr_oor  = out_of_range(wr_addr);
  assign w_rd_oor  = out_of_range(rd_addr);
  assign range_err = r_range_err;
`else
  // Without range checking the upper address bits and byte offset are ignored.
  logic w_unused;
  assign w_unused = ^{wr_addr[31:ADDR_W+2], wr_addr[1:0],
                      rd_addr[31:ADDR_W+2], rd_addr[1:0]};
  assign w_wr_oor = 1'b0;
  assign w_rd_oor = 1'b0;
`endif

  // State register plus all registered outputs and datapath state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= CNT_ZERO;
      r_sram_addr  <= ADDR_W'(0);
      r_sram_wdata <= 32'd0;
      r_sram_we    <= 1'b0;
      r_rd_data    <= 32'd0;
      r_rd_ready   <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_is_wr      <= 1'b0;
      r_oor        <= 1'b0;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
      r_range_err  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_sram_we    <= w_sram_we_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_ready   <= w_rd_ready_nxt;
      r_wr_ready   <= w_wr_ready_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_is_wr      <= w_is_wr_nxt;
      r_oor        <= w_oor_nxt;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
      r_range_err  <= w_range_err_nxt;
`endif
    end
  end

  // Next-state logic: write wins over read in IDLE; both leave their wait state when the counter expires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (wr_valid) begin
          w_state_nxt = S_WRITE;
        end else if (rd_valid) begin
          w_state_nxt = S_READ_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE, S_READ_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the in-flight access context
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_sram_addr_nxt  = r_sram_addr;
    w_sram_wdata_nxt = r_sram_wdata;
    w_sram_we_nxt    = 1'b0;
    w_rd_data_nxt    = r_rd_data;
    w_rd_ready_nxt   = 1'b0;
    w_wr_ready_nxt   = 1'b0;
    w_is_wr_nxt      = r_is_wr;
    w_oor_nxt        = r_oor;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    w_range_err_nxt  = r_range_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (wr_valid) begin
          w_sram_addr_nxt  = w_wr_idx;
          w_sram_wdata_nxt = wr_data;
          w_sram_we_nxt    = ~w_wr_oor;
          w_cnt_nxt        = WR_LOAD;
          w_is_wr_nxt      = 1'b1;
          w_oor_nxt        = w_wr_oor;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
          w_range_err_nxt  = r_range_err | w_wr_oor;
`endif
        end else if (rd_valid) begin
          w_sram_addr_nxt  = w_rd_idx;
          w_cnt_nxt        = RD_LOAD;
          w_is_wr_nxt      = 1'b0;
          w_oor_nxt        = w_rd_oor;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
          w_range_err_nxt  = r_range_err | w_rd_oor;
`endif
        end else begin
          w_cnt_nxt        = r_cnt;
        end
      end
      S_WRITE, S_READ_WAIT: begin
        // With the counter at zero, sram_rdata is valid this cycle for a read, so it is captured at this edge
        if (r_cnt == CNT_ZERO) begin
          if (r_is_wr) begin
            w_wr_ready_nxt = 1'b1;
          end else begin
            w_rd_ready_nxt = 1'b1;
            w_rd_data_nxt  = r_oor ? 32'h0000_0000 : sram_rdata;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_cnt_nxt = CNT_ZERO;
      end
      default: begin
        w_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  assign rd_data    = r_rd_data;
  assign rd_ready   = r_rd_ready;
  assign wr_ready   = r_wr_ready;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_we    = r_sram_we;
  assign busy       = r_busy;

endmodule

// File: tb/tb_main_mem_ctrl.sv
module tb_main_mem_ctrl;
  localparam int ADDR_W = 16;
  localparam int RL     = 2;

`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
  localparam logic [31:0] EXP_UNALIGNED = 32'h0000_0000;
  localparam logic [31:0] EXP_HIGHBITS  = 32'h0000_0000;
  localparam logic [31:0] EXP_WRAP      = 32'h0000_0000;
  localparam logic        EXP_WRAP_WE   = 1'b0;
`else
  localparam logic [31:0] EXP_UNALIGNED = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_HIGHBITS  = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_WRAP      = 32'h55AA_55AA;
  localparam logic        EXP_WRAP_WE   = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       rd_addr, wr_addr, wr_data, rd_data, sram_wdata, sram_rdata;
  logic              rd_valid, wr_valid, rd_ready, wr_ready, sram_we, busy;
  logic [ADDR_W-1:0] sram_addr;
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
  logic              range_err;
`endif

  main_mem_ctrl #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_rdata(sram_rdata), .busy(busy)
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write on the edge, read data appears RL cycles after the address
  logic [31:0] mem  [0:255];
  logic [31:0] pipe [0:RL-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      for (int i = 0; i < RL; i++) pipe[i] <= 32'd0;
    end else begin
      if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
      pipe[0] <= mem[sram_addr[7:0]];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign sram_rdata = pipe[RL-1];

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every ready pulse is matched against the next scoreboard entry
  always @(negedge clk) begin
    if (!reset && (rd_ready || wr_ready)) begin
      if (rd_ready) rd_pulses++;
      if (wr_ready) wr_pulses++;
      chk("ready_exclusive", 32'(rd_ready & wr_ready), 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: rd_ready=%b wr_ready=%b with nothing outstanding (cycle %0d)",
                 rd_ready, wr_ready, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ready_channel", 32'(rd_ready), 32'(mon_e.is_rd));
        chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.is_rd) chk("rd_data", rd_data, mon_e.data);
      end
    end
  end

  // Waits for a ready pulse on one channel, then returns just after the following edge
  task automatic wait_ready(input logic want_rd);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (want_rd ? rd_ready : wr_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: no %s ready within 20 cycles", want_rd ? "rd" : "wr");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic exp_we, input logic [15:0] exp_idx);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    sb.push_back('{1'b0, 32'd0, cyc + 3});
    @(posedge clk);
    @(negedge clk);
    chk("wr_sram_we", 32'(sram_we), 32'(exp_we));
    chk("wr_busy", 32'(busy), 32'd1);
    if (exp_we) begin
      chk("wr_sram_addr", 32'(sram_addr), 32'(exp_idx));
      chk("wr_sram_wdata", sram_wdata, d);
    end
    @(negedge clk);
    chk("wr_we_one_cycle", 32'(sram_we), 32'd0);
    chk("wr_busy_mid", 32'(busy), 32'd1);
    wait_ready(1'b0);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d);
    rd_addr  = a;
    rd_valid = 1'b1;
    sb.push_back('{1'b1, exp_d, cyc + 4});
    @(posedge clk);
    @(negedge clk);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_no_we", 32'(sram_we), 32'd0);
    wait_ready(1'b1);
    rd_valid = 1'b0;
  endtask

  task automatic do_both(input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra, input logic [31:0] exp_d);
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr  = ra;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    sb.push_back('{1'b0, 32'd0, cyc + 3});
    sb.push_back('{1'b1, exp_d, cyc + 8});
    wait_ready(1'b0);
    wr_valid = 1'b0;
    wait_ready(1'b1);
    rd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses_before;

  initial begin
    reset = 1'b1;
    rd_addr = 32'd0; wr_addr = 32'd0; wr_data = 32'd0;
    rd_valid = 1'b0; wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_rd_ready", 32'(rd_ready), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    chk("reset_sram_we", 32'(sram_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    chk("reset_range_err", 32'(range_err), 32'd0);
`endif
    @(posedge clk); #1;

    // Basic write then read of the same word
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 16'd4);
    do_read(32'h0000_0010, 32'hDEAD_BEEF);
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    chk("range_err_clean", 32'(range_err), 32'd0);
`endif
    // Byte offset and high address bits: ignored by default, out of range when checked
    do_read(32'h0000_0013, EXP_UNALIGNED);
    do_read(32'h0004_0010, EXP_HIGHBITS);

    // Simultaneous requests: write first, then read; the read sees a just-written word
    do_both(32'h0000_0020, 32'h1234_5678, 32'h0000_0010, 32'hDEAD_BEEF);
    do_both(32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0020, 32'hCAFE_F00D);

    // Valid held through the pulse: exactly one response, then idle
    pulses_before = rd_pulses;
    do_read(32'h0000_0020, 32'hCAFE_F00D);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("single_pulse", 32'(rd_pulses - pulses_before), 32'd1);
    chk("idle_after_pulse", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Reset in READ_WAIT aborts the read
    pulses_before = rd_pulses;
    rd_addr  = 32'h0000_0010;
    rd_valid = 1'b1;
    @(posedge clk); #1;
    rd_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sram_we", 32'(sram_we), 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);
    chk("abort_rd_ready", 32'(rd_ready), 32'd0);
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    chk("abort_range_err", 32'(range_err), 32'd0);
`endif
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_no_pulse", 32'(rd_pulses - pulses_before), 32'd0);
    @(posedge clk); #1;

    // Address 0x0004_0000: wraps to word 0 by default, rejected when range checked
    do_write(32'h0004_0000, 32'h55AA_55AA, EXP_WRAP_WE, 16'd0);
`ifdef MAIN_MEM_CTRL_RANGE_CHECK_EN
    chk("range_err_set", 32'(range_err), 32'd1);
    do_read(32'h0004_0000, 32'h0000_0000);
`endif
    do_read(32'h0000_0000, EXP_WRAP);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
